// File: rtl/quad_map_mc_pkg.sv
// Shared definitions for the chaotic-map blocks: controller states and
// fixed-point helpers evaluated at 64-bit precision.
package chaotic_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  function automatic longint one_q(input int w);
    return 64'sd1 <<< (w - 2);
  endfunction

  // Clamp a wide signed value into the range of a w-bit two's-complement word.
  function automatic longint sat_w(input longint value, input int w);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (value > hi) return hi;
    else if (value < lo) return lo;
    else return value;
  endfunction

endpackage

// File: rtl/quad_map_mc_dp.sv
// Three-stage datapath for x' = 1 - r*x^2 in Q2.(W-2): square, multiply,
// then subtract/saturate combinationally into the caller's output register.
module quad_map_dp
  import chaotic_pkg::*;
#(
  parameter int W   = 16,
  parameter int CHW = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           in_valid,
  input  logic [CHW-1:0] in_ch,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   r,
  output logic           out_valid,
  output logic [CHW-1:0] out_ch,
  output logic [W-1:0]   y
);

  localparam int PW = W + 4;

  logic                 s1_valid_q;
  logic [CHW-1:0]       s1_ch_q;
  logic signed [W+1:0]  s1_sq_q;
  logic signed [W+1:0]  sq_d;
  logic signed [W-1:0]  s1_r_q;
  logic                 s2_valid_q;
  logic [CHW-1:0]       s2_ch_q;
  logic signed [PW-1:0] s2_p_q;
  logic signed [PW-1:0] p_d;

  // Products are formed at full width so the floor shift sees every bit.
  always_comb begin
    sq_d = (W+2)'(((2*W)'($signed(x)) * (2*W)'($signed(x))) >>> (W - 2));
    p_d  = PW'(((2*W+2)'(s1_r_q) * (2*W+2)'(s1_sq_q)) >>> (W - 2));
    y    = W'(sat_w(one_q(W) - longint'(s2_p_q), W));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_sq_q    <= '0;
      s1_r_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_ch_q    <= '0;
      s2_p_q     <= '0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      s1_ch_q    <= in_ch;
      s1_sq_q    <= sq_d;
      s1_r_q     <= $signed(r);
      s2_valid_q <= s1_valid_q;
      s2_ch_q    <= s1_ch_q;
      s2_p_q     <= p_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_ch    = s2_ch_q;

endmodule

// File: rtl/quad_map_mc.sv
// Multi-channel quadratic chaotic map iterator: round-robin issue into a shared
// 3-stage datapath, per-channel state writeback and a backpressured output stream.
module quad_map_mc
  import chaotic_pkg::*;
#(
  parameter int W   = 16,
  parameter int NCH = 4,
  parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           seed_we,
  input  logic [CHW-1:0] seed_ch,
  input  logic [W-1:0]   seed_x,
  input  logic [W-1:0]   seed_r,
  output logic           seed_err,
  input  logic           run,
  output logic           busy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CHW-1:0] out_ch,
  output logic [W-1:0]   out_data
);

  // At least three slots per round so a result lands before its channel reissues.
  localparam int S  = (NCH > 3) ? NCH : 3;
  localparam int SW = $clog2(S);
  localparam logic [SW-1:0] S_LAST = SW'(S - 1);
  localparam logic [SW:0]   NCH_S  = (SW+1)'(NCH);
  localparam logic [CHW:0]  NCH_C  = (CHW+1)'(NCH);

  state_e         state_q, state_d;
  logic [SW-1:0]  s_q, s_d;
  logic [1:0]     inflight_q, inflight_d;
  logic           out_valid_q, out_valid_d;
  logic [CHW-1:0] out_ch_q;
  logic [W-1:0]   out_data_q;
  logic           seed_err_q;
  logic [W-1:0]   x_q [NCH];
  logic [W-1:0]   r_q [NCH];

  logic           en, issue_slot, issue, load, seed_ok, busy_w;
  logic [CHW-1:0] issue_ch;
  logic           dp_valid;
  logic [CHW-1:0] dp_ch;
  logic [W-1:0]   dp_y;

  assign en         = !(out_valid_q && !out_ready);
  assign issue_slot = (state_q == RUN) && run && en;
  assign issue      = issue_slot && ({1'b0, s_q} < NCH_S);
  assign issue_ch   = s_q[CHW-1:0];
  assign load       = en && dp_valid;
  assign busy_w     = (state_q == RUN) || (inflight_q != 2'd0) || out_valid_q;
  assign seed_ok    = seed_we && !busy_w && ({1'b0, seed_ch} < NCH_C);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (run) state_d = RUN;
      RUN:   if (!run) state_d = DRAIN;
      DRAIN: begin
        if (run) state_d = RUN;
        else if (inflight_q == 2'd0 && (!out_valid_q || out_ready)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The slot counter and in-flight count only move on cycles the pipeline advances.
  always_comb begin
    s_d = s_q;
    if (state_q == IDLE && run) s_d = '0;
    else if (issue_slot)        s_d = (s_q == S_LAST) ? '0 : s_q + SW'(1);
    inflight_d = inflight_q;
    case ({issue, load})
      2'b10:   inflight_d = inflight_q + 2'd1;
      2'b01:   inflight_d = inflight_q - 2'd1;
      default: inflight_d = inflight_q;
    endcase
    out_valid_d = load || (out_valid_q && !out_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q         <= '0;
      inflight_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      seed_err_q  <= 1'b0;
    end else begin
      s_q         <= s_d;
      inflight_q  <= inflight_d;
      out_valid_q <= out_valid_d;
      seed_err_q  <= seed_we && busy_w;
      if (load) begin
        out_ch_q   <= dp_ch;
        out_data_q <= dp_y;
      end
    end
  end

  // Seeds only land while idle, so they can never collide with a writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        x_q[c] <= '0;
        r_q[c] <= '0;
      end
    end else begin
      if (seed_ok) begin
        x_q[seed_ch] <= seed_x;
        r_q[seed_ch] <= seed_r;
      end
      if (load) x_q[dp_ch] <= dp_y;
    end
  end

  quad_map_dp #(
    .W   (W),
    .CHW (CHW)
  ) u_dp (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (issue),
    .in_ch     (issue_ch),
    .x         (x_q[issue_ch]),
    .r         (r_q[issue_ch]),
    .out_valid (dp_valid),
    .out_ch    (dp_ch),
    .y         (dp_y)
  );

  assign seed_err  = seed_err_q;
  assign busy      = busy_w;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_quad_map_mc.sv
// Self-checking bench for quad_map_mc: a 4-channel instance against a
// plain-arithmetic map model, plus a single-channel instance for fixed sequences.
module tb_quad_map_mc;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         seedWe, seedErr, run, busy, outValid, outReady;
  logic [1:0]   seedCh, outCh;
  logic [W-1:0] seedX, seedR, outData;

  logic         seedWe1, seedErr1, run1, busy1, outValid1, outReady1;
  logic [0:0]   seedCh1, outCh1;
  logic [W-1:0] seedX1, seedR1, outData1;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] modelX [4];
  logic [W-1:0] modelR [4];
  logic [W-1:0] seedXs [4];
  logic [W-1:0] seedRs [4];
  logic [W-1:0] refData [$];
  logic [1:0]   refCh [$];

  quad_map_mc #(.W(W), .NCH(4)) dut4 (
    .clk(clk), .reset(reset), .seed_we(seedWe), .seed_ch(seedCh), .seed_x(seedX),
    .seed_r(seedR), .seed_err(seedErr), .run(run), .busy(busy), .out_valid(outValid),
    .out_ready(outReady), .out_ch(outCh), .out_data(outData)
  );

  quad_map_mc #(.W(W), .NCH(1)) dut1 (
    .clk(clk), .reset(reset), .seed_we(seedWe1), .seed_ch(seedCh1), .seed_x(seedX1),
    .seed_r(seedR1), .seed_err(seedErr1), .run(run1), .busy(busy1), .out_valid(outValid1),
    .out_ready(outReady1), .out_ch(outCh1), .out_data(outData1)
  );

  // x' = 1 - r*x^2 evaluated on real-valued fixed point with floor and clamp.
  function automatic logic [W-1:0] mapStep(input logic [W-1:0] x, input logic [W-1:0] r);
    longint xs, rs, sq, p, y;
    xs = longint'($signed(x));
    rs = longint'($signed(r));
    sq = (xs * xs) >>> 14;
    p  = (rs * sq) >>> 14;
    y  = 64'sd16384 - p;
    if (y > 64'sd32767) y = 64'sd32767;
    if (y < -64'sd32768) y = -64'sd32768;
    return 16'(y);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain4(output bit ok);
    run = 1'b0; outReady = 1'b1; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      ok = !busy;
    end
    step();
  endtask

  task automatic drain1(output bit ok);
    run1 = 1'b0; outReady1 = 1'b1; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      ok = !busy1;
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    seedWe = 0; seedCh = 0; seedX = 0; seedR = 0; run = 0; outReady = 1;
    seedWe1 = 0; seedCh1 = 0; seedX1 = 0; seedR1 = 0; run1 = 0; outReady1 = 1;
    step(); step();
    checks++;
    if (outValid !== 1'b0 || outCh !== 2'd0 || outData !== 16'h0 || busy !== 1'b0 || seedErr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset4: valid=%b ch=%0d data=%h busy=%b err=%b, required all zero", outValid, outCh, outData, busy, seedErr);
    end
    checks++;
    if (outValid1 !== 1'b0 || outCh1 !== 1'b0 || outData1 !== 16'h0 || busy1 !== 1'b0 || seedErr1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset1: valid=%b ch=%0d data=%h busy=%b err=%b, required all zero", outValid1, outCh1, outData1, busy1, seedErr1);
    end
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || outValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset_idle: busy=%b valid=%b, required 0 0", busy, outValid);
    end
  endtask

  task automatic test_fixed_cycle();
    int got, cyc;
    bit ok;
    logic [W-1:0] expD;
    seedWe1 = 1; seedCh1 = 0; seedX1 = 16'h0000; seedR1 = 16'h4000; run1 = 1; outReady1 = 1;
    step();
    seedWe1 = 0;
    got = 0; cyc = 1;
    while (got < 6 && cyc < 100) begin
      step(); cyc++;
      if (outValid1) begin
        expD = (got % 2 == 0) ? 16'h4000 : 16'h0000;
        checks++;
        if (outData1 !== expD) begin
          failures++;
          $display("[TB] FAIL fixed_data[%0d]: got %h required %h", got, outData1, expD);
        end
        checks++;
        if (cyc != 4 + 3 * got) begin
          failures++;
          $display("[TB] FAIL fixed_timing[%0d]: arrived cycle %0d required %0d", got, cyc, 4 + 3 * got);
        end
        got++;
      end
    end
    checks++;
    if (got != 6) begin
      failures++;
      $display("[TB] FAIL fixed_count: got %0d samples required 6", got);
    end
    drain1(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL fixed_drain: busy still %b, required 0", busy1);
    end
  endtask

  // Seed one value on the single-channel instance and check the first few results.
  task automatic test_single_seed(input string name, input logic [W-1:0] x, input logic [W-1:0] r,
                                  input logic [W-1:0] exp0, input logic [W-1:0] exp1);
    int got, cyc;
    bit ok;
    logic [W-1:0] expD;
    seedWe1 = 1; seedCh1 = 0; seedX1 = x; seedR1 = r; run1 = 1; outReady1 = 1;
    step();
    seedWe1 = 0;
    got = 0; cyc = 0;
    while (got < 2 && cyc < 50) begin
      step(); cyc++;
      if (outValid1) begin
        expD = (got == 0) ? exp0 : exp1;
        checks++;
        if (outData1 !== expD) begin
          failures++;
          $display("[TB] FAIL %s[%0d]: got %h required %h", name, got, outData1, expD);
        end
        got++;
      end
    end
    checks++;
    if (got != 2) begin
      failures++;
      $display("[TB] FAIL %s_count: got %0d samples required 2", name, got);
    end
    drain1(ok);
  endtask

  task automatic test_interleave();
    int got, cyc, prevCyc;
    bit ok;
    logic [W-1:0] expD;
    logic [1:0] expC;
    for (int c = 0; c < 4; c++) begin
      seedXs[c] = 16'($urandom);
      seedRs[c] = 16'($urandom);
      seedWe = 1; seedCh = 2'(c); seedX = seedXs[c]; seedR = seedRs[c];
      modelX[c] = seedXs[c]; modelR[c] = seedRs[c];
      step();
    end
    seedWe = 0; run = 1; outReady = 1;
    refData.delete(); refCh.delete();
    got = 0; cyc = 0; prevCyc = 0;
    while (got < 24 && cyc < 200) begin
      step(); cyc++;
      if (outValid) begin
        expC = 2'(got % 4);
        expD = mapStep(modelX[expC], modelR[expC]);
        modelX[expC] = expD;
        refData.push_back(expD); refCh.push_back(expC);
        checks++;
        if (outCh !== expC || outData !== expD) begin
          failures++;
          $display("[TB] FAIL interleave[%0d]: got ch%0d %h required ch%0d %h", got, outCh, outData, expC, expD);
        end
        if (got > 0) begin
          checks++;
          if (cyc != prevCyc + 1) begin
            failures++;
            $display("[TB] FAIL interleave_rate[%0d]: gap %0d cycles required 1", got, cyc - prevCyc);
          end
        end
        prevCyc = cyc;
        got++;
      end
    end
    checks++;
    if (got != 24) begin
      failures++;
      $display("[TB] FAIL interleave_count: got %0d required 24", got);
    end
    drain4(ok);
  endtask

  task automatic test_backpressure();
    int got, cyc;
    bit ok, prevValid, prevReady;
    logic [W-1:0] prevData;
    logic [1:0] prevCh;
    for (int c = 0; c < 4; c++) begin
      seedWe = 1; seedCh = 2'(c); seedX = seedXs[c]; seedR = seedRs[c];
      step();
    end
    seedWe = 0; run = 1; outReady = 0;
    prevValid = 0; prevReady = 0; prevData = 0; prevCh = 0;
    got = 0; cyc = 0;
    while (got < 24 && cyc < 2000) begin
      step(); cyc++;
      if (prevValid && !prevReady) begin
        checks++;
        if (outValid !== 1'b1 || outData !== prevData || outCh !== prevCh) begin
          failures++;
          $display("[TB] FAIL stall_hold: got v%b ch%0d %h required v1 ch%0d %h", outValid, outCh, outData, prevCh, prevData);
        end
      end
      outReady = 1'($urandom_range(0, 1));
      if (outValid && outReady) begin
        checks++;
        if (outCh !== refCh[got] || outData !== refData[got]) begin
          failures++;
          $display("[TB] FAIL bp_seq[%0d]: got ch%0d %h required ch%0d %h", got, outCh, outData, refCh[got], refData[got]);
        end
        got++;
      end
      prevValid = outValid; prevReady = outReady; prevData = outData; prevCh = outCh;
    end
    checks++;
    if (got != 24) begin
      failures++;
      $display("[TB] FAIL bp_count: got %0d required 24", got);
    end
    drain4(ok);
  endtask

  task automatic test_control_edges();
    int got, cyc, lastStep;
    bit ok, done;
    logic [W-1:0] expD;
    for (int c = 0; c < 4; c++) begin
      seedWe = 1; seedCh = 2'(c); seedX = seedXs[c]; seedR = seedRs[c];
      modelX[c] = seedXs[c]; modelR[c] = seedRs[c];
      step();
    end
    seedWe = 0; outReady = 0; run = 1;
    for (int i = 0; i < 6; i++) step();
    run = 0;
    step();
    seedWe = 1; seedCh = 0; seedX = 16'h1234; seedR = 16'h0000;
    step();
    seedWe = 0;
    checks++;
    if (seedErr !== 1'b1) begin
      failures++;
      $display("[TB] FAIL seed_err_pulse: got %b required 1", seedErr);
    end
    step();
    checks++;
    if (seedErr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL seed_err_width: got %b required 0", seedErr);
    end
    checks++;
    if (busy !== 1'b1 || outValid !== 1'b1 || outCh !== 2'd0) begin
      failures++;
      $display("[TB] FAIL drain_hold: got busy%b v%b ch%0d required busy1 v1 ch0", busy, outValid, outCh);
    end

    outReady = 1; got = 0; cyc = 0; lastStep = -1; done = 0;
    while (cyc < 30 && !done) begin
      if (outValid) begin
        expD = mapStep(modelX[got % 4], modelR[got % 4]);
        modelX[got % 4] = expD;
        checks++;
        if (outCh !== 2'(got) || outData !== expD) begin
          failures++;
          $display("[TB] FAIL drain_data[%0d]: got ch%0d %h required ch%0d %h", got, outCh, outData, got, expD);
        end
        got++;
        lastStep = cyc;
      end else if (!busy) begin
        done = 1;
      end
      if (!done) begin
        step(); cyc++;
      end
    end
    checks++;
    if (got != 3 || cyc != lastStep + 1) begin
      failures++;
      $display("[TB] FAIL drain_end: got %0d samples busy low at %0d, required 3 samples busy low at %0d", got, cyc, lastStep + 1);
    end
    step();

    run = 1; cyc = 0;
    while (!outValid && cyc < 20) begin
      step(); cyc++;
    end
    expD = mapStep(modelX[0], modelR[0]);
    checks++;
    if (outValid !== 1'b1 || outCh !== 2'd0 || outData !== expD) begin
      failures++;
      $display("[TB] FAIL seed_ignored: got v%b ch%0d %h required v1 ch0 %h", outValid, outCh, outData, expD);
    end

    step(); step();
    reset = 1;
    step();
    checks++;
    if (outValid !== 1'b0 || outCh !== 2'd0 || outData !== 16'h0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_run: got v%b ch%0d %h busy%b required all zero", outValid, outCh, outData, busy);
    end
    reset = 0;
    got = 0; cyc = 0;
    while (got < 4 && cyc < 40) begin
      step(); cyc++;
      if (outValid) begin
        checks++;
        if (outCh !== 2'(got) || outData !== 16'h4000) begin
          failures++;
          $display("[TB] FAIL cleared_state[%0d]: got ch%0d %h required ch%0d 4000", got, outCh, outData, got);
        end
        got++;
      end
    end
    checks++;
    if (got != 4) begin
      failures++;
      $display("[TB] FAIL cleared_count: got %0d required 4", got);
    end
    drain4(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL final_drain: busy %b required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_cycle();
    test_single_seed("arith", 16'h2000, 16'h7000, 16'h2400, mapStep(16'h2400, 16'h7000));
    test_single_seed("saturate", 16'h8000, 16'h7FFF, 16'h8000, 16'h8000);
    test_interleave();
    test_backpressure();
    test_control_edges();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
